// File: rtl/byte_lane_packer_pkg.sv
// byte_lane_pkg: shared defaults and small types for the byte lane packer
// and its 2-entry output FIFO.
package byte_lane_pkg;

    localparam int DEFAULT_LANES = 4;
    localparam int DEFAULT_BW    = 8;

    // FIFO occupancy, range 0..2.
    typedef logic [1:0] fifo_cnt_t;

    // FIFO read/write pointer; one bit addresses both entries and wraps naturally.
    typedef logic fifo_ptr_t;

endpackage : byte_lane_pkg

// File: rtl/byte_lane_packer_fifo2.sv
// byte_lane_fifo2: two-entry FIFO holding completed packer words.
// The caller only pushes when count != 2 and only pops when count != 0.
// The head entry is always visible on head_data, even when empty (stale).
module byte_lane_fifo2
    import byte_lane_pkg::*;
#(
    parameter int W = DEFAULT_LANES * DEFAULT_BW + DEFAULT_LANES + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] r_mem [0:1];
    fifo_ptr_t    r_rd_ptr;
    fifo_ptr_t    r_wr_ptr;
    fifo_cnt_t    r_count;

    // Storage, pointers and occupancy; push and pop may share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only two entries, so the storage is cleared on reset; this keeps the stale head at zero after reset.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule : byte_lane_fifo2

// File: rtl/byte_lane_packer.sv
// byte_lane_packer: packs a stream of BW-bit bytes into LANES-lane words.
// Lane k of a word sits at [k*BW +: BW]; a word closes on its last lane or
// on in_last, and closed words queue in a 2-entry FIFO.
// Build option BYTE_LANE_PACKER_BSWAP_EN: present lane 0 at the MSB lane of
// out_data and bit-reverse out_keep to match; FIFO storage is unchanged.
module byte_lane_packer
    import byte_lane_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int BW    = DEFAULT_BW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BW-1:0]         in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*BW-1:0]   out_data,
    output logic [LANES-1:0]      out_keep,
    output logic                  out_last
);

    localparam int IDX_W   = $clog2(LANES);
    localparam int WORD_W  = LANES * BW;
    localparam int ENTRY_W = WORD_W + LANES + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [IDX_W-1:0]   r_idx;
    logic [WORD_W-1:0]  r_acc;
    logic [LANES-1:0]   r_keep;

    logic [WORD_W-1:0]  w_acc_merged;
    logic [LANES-1:0]   w_keep_merged;
    logic               w_acc_beat;
    logic               w_close;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head_data;
    logic [1:0]         w_count;
    logic [WORD_W-1:0]  w_head_word;
    logic [LANES-1:0]   w_head_keep;
    logic               w_head_last;

    // Backpressure depends only on registered occupancy, never on out_ready.
    assign in_ready   = (w_count != 2'd2);
    assign w_acc_beat = in_valid && in_ready;
    assign w_close    = w_acc_beat && ((r_idx == LAST_IDX) || in_last);
    assign out_valid  = (w_count != 2'd0);
    assign w_pop      = out_valid && out_ready;

    // Overlay the incoming byte and its keep bit onto the accumulator at the active lane.
    always_comb begin
        // NOTE: every output gets a default before the partial overwrite, so no latch is inferred.
        w_acc_merged  = r_acc;
        w_keep_merged = r_keep;
        w_acc_merged[r_idx*BW +: BW] = in_data;
        w_keep_merged[r_idx]         = 1'b1;
    end

    // Lane index and accumulator: advance on a plain accept, clear when the word closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_keep <= '0;
        end else if (w_acc_beat) begin
            // NOTE: non-blocking updates so every flop samples pre-edge values, independent of statement order.
            if (w_close) begin
                r_idx  <= '0;
                r_acc  <= '0;
                r_keep <= '0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
                r_acc  <= w_acc_merged;
                r_keep <= w_keep_merged;
            end
        end
    end

    // The closing byte is merged in the same edge that writes the FIFO entry.
    assign w_push_data = {w_acc_merged, w_keep_merged, in_last};

    byte_lane_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_close),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (w_head_data),
        .count     (w_count)
    );

    assign {w_head_word, w_head_keep, w_head_last} = w_head_data;

`ifdef BYTE_LANE_PACKER_BSWAP_EN
    assign out_data = {<<BW{w_head_word}};
    assign out_keep = {<<{w_head_keep}};
`else
    assign out_data = w_head_word;
    assign out_keep = w_head_keep;
`endif
    assign out_last = w_head_last;

endmodule : byte_lane_packer

// File: tb/tb_byte_lane_packer.sv
// tb_byte_lane_packer: randomized and directed stimulus for byte_lane_packer,
// with a queue-based reference model and an independent output monitor.
module tb_byte_lane_packer;

    localparam int LANES = 4;
    localparam int BW    = 8;

`ifdef BYTE_LANE_PACKER_BSWAP_EN
    localparam logic [31:0] EXP_FULL    = 32'h11223344;
    localparam logic [3:0]  EXP_FULL_K  = 4'b1111;
    localparam logic [31:0] EXP_PART    = 32'hAABB0000;
    localparam logic [3:0]  EXP_PART_K  = 4'b1100;
    localparam logic [31:0] EXP_SINGLE  = 32'h5C000000;
    localparam logic [3:0]  EXP_SINGLE_K = 4'b1000;
    localparam logic [31:0] EXP_SECOND  = 32'h05060708;
`else
    localparam logic [31:0] EXP_FULL    = 32'h44332211;
    localparam logic [3:0]  EXP_FULL_K  = 4'b1111;
    localparam logic [31:0] EXP_PART    = 32'h0000BBAA;
    localparam logic [3:0]  EXP_PART_K  = 4'b0011;
    localparam logic [31:0] EXP_SINGLE  = 32'h0000005C;
    localparam logic [3:0]  EXP_SINGLE_K = 4'b0001;
    localparam logic [31:0] EXP_SECOND  = 32'h08070605;
`endif

    typedef struct packed {
        logic [LANES*BW-1:0] data;
        logic [LANES-1:0]    keep;
        logic                last;
    } exp_word_t;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [BW-1:0]       in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*BW-1:0] out_data;
    logic [LANES-1:0]    out_keep;
    logic                out_last;

    int checks   = 0;
    int failures = 0;
    int words_out = 0;
    int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random per cycle

    exp_word_t   exp_q[$];
    logic [7:0]  cur_bytes[$];

    byte_lane_packer #(
        .LANES (LANES),
        .BW    (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Build the expected word from the bytes collected so far: byte k goes to
    // lane k (or lane LANES-1-k when lanes are reversed), unused lanes stay 0.
    function automatic exp_word_t make_word(input logic last);
        exp_word_t w;
        int lane;
        w.data = '0;
        w.keep = '0;
        w.last = last;
        for (int k = 0; k < cur_bytes.size(); k++) begin
`ifdef BYTE_LANE_PACKER_BSWAP_EN
            lane = LANES - 1 - k;
`else
            lane = k;
`endif
            w.data[lane*BW +: BW] = cur_bytes[k];
            w.keep[lane] = 1'b1;
        end
        return w;
    endfunction

    // Monitor: sampled on the falling edge, mid-cycle, where the handshakes
    // that complete on the next rising edge are stable.
    always @(negedge clk) begin
        exp_word_t e;
        if (rst_n) begin
            check("out_valid_vs_model", 64'(out_valid), 64'(exp_q.size() != 0));
            check("in_ready_vs_model", 64'(in_ready), 64'(exp_q.size() != 2));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_out_data", 64'(out_data), 64'(e.data));
                check("sb_out_keep", 64'(out_keep), 64'(e.keep));
                check("sb_out_last", 64'(out_last), 64'(e.last));
                words_out++;
            end
            if (in_valid && in_ready) begin
                cur_bytes.push_back(in_data);
                if (cur_bytes.size() == LANES || in_last) begin
                    exp_q.push_back(make_word(in_last));
                    cur_bytes.delete();
                end
            end
        end
    end

    // Downstream ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic set_ready(input int mode);
        ready_mode = mode;
        if (mode == 0) out_ready = 1'b0;
        if (mode == 1) out_ready = 1'b1;
    endtask

    // Present one byte (called just after a rising edge) and hold it until accepted.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: byte %0h not accepted after %0d cycles", d, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Let every expected word leave the DUT, within a bounded number of cycles.
    task automatic drain();
        int waited;
        waited = 0;
        set_ready(1);
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d words still pending", exp_q.size());
        end
        idle(1);
    endtask

    initial begin
        int words_before;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Full word.
        set_ready(1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_data", 64'(out_data), 64'(EXP_FULL));
        check("full_keep", 64'(out_keep), 64'(EXP_FULL_K));
        check("full_last", 64'(out_last), 64'd0);

        // Partial word closed by in_last.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        check("part_data", 64'(out_data), 64'(EXP_PART));
        check("part_keep", 64'(out_keep), 64'(EXP_PART_K));
        check("part_last", 64'(out_last), 64'd1);
        drain();

        // Fill both entries with out_ready low, then release.
        set_ready(0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), 1'b0);
        check("full_fifo_in_ready", 64'(in_ready), 64'd0);
        check("full_fifo_valid", 64'(out_valid), 64'd1);
        fork
            for (int i = 8; i < 12; i++) send_byte(8'(8'h30 + i), 1'b0);
            begin
                idle(5);
                set_ready(1);
            end
        join
        drain();

        // Push and pop on the same edge at count 1.
        set_ready(0);
        for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b0);
        set_ready(1);
        send_byte(8'h08, 1'b0);
        check("pushpop_valid", 64'(out_valid), 64'd1);
        check("pushpop_head", 64'(out_data), 64'(EXP_SECOND));
        drain();

        // Single-lane word.
        send_byte(8'h5C, 1'b1);
        check("single_data", 64'(out_data), 64'(EXP_SINGLE));
        check("single_keep", 64'(out_keep), 64'(EXP_SINGLE_K));
        check("single_last", 64'(out_last), 64'd1);
        drain();

        // Asynchronous reset with one word queued and a partial word pending.
        set_ready(0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_data", 64'(out_data), 64'd0);
        exp_q.delete();
        cur_bytes.delete();
        words_before = words_out;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ready(1);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC4, 1'b0);
        drain();
        check("post_rst_word_count", 64'(words_out - words_before), 64'd1);

        // Randomized traffic with random gaps, word ends and backpressure.
        set_ready(2);
        for (int i = 0; i < 400; i++) begin
            idle($urandom_range(0, 2));
            send_byte(8'($urandom), $urandom_range(0, 4) == 0);
        end
        send_byte(8'($urandom), 1'b1);
        drain();
        check("final_partial_empty", 64'(cur_bytes.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_byte_lane_packer
